// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: operand side (in_*) and result side (out_*).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             b_negate;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, b_negate, op, out_ready,
        input  in_ready, out_valid, result, carry_out, zero, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, b_negate, op, out_ready,
        output in_ready, out_valid, result, carry_out, zero, negative, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and result/flag register.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (op 110, BUSY state).
module alu_seq #(
    parameter int unsigned WIDTH = 24
) (
    input logic        clk,
    input logic        rst_n,
    alu_seq_if.slave   bus
);
    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpXor = 3'b010;
    localparam logic [2:0] OpAdd = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpNor = 3'b101;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             busy, accept, consume, in_ready;
    logic             wr;
    logic [WIDTH-1:0] wr_res;
    logic             wr_c, wr_v;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0]         OpMul   = 3'b110;
    localparam logic [0:0]         StIdle  = 1'b0;
    localparam logic [0:0]         StBusy  = 1'b1;
    localparam int unsigned        CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0]    LastCnt = CntW'(WIDTH - 1);

    logic [0:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    assign busy = (state_q == StBusy);
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !busy && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_q && bus.out_ready;

    always_comb begin
        b_eff   = bus.b_negate ? ~bus.b : bus.b;
        sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.carry_in};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.op)
            OpAnd: alu_res = bus.a & bus.b;
            OpOr:  alu_res = bus.a | bus.b;
            OpXor: alu_res = bus.a ^ bus.b;
            OpNor: alu_res = ~(bus.a | bus.b);
            OpAdd: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        wr          = 1'b0;
        wr_res      = alu_res;
        wr_c        = alu_c;
        wr_v        = alu_v;
        if (consume) out_valid_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (state_q == StIdle) begin
            if (accept) begin
                if (bus.op == OpMul) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end else begin
                    wr = 1'b1;
                end
            end
        end else begin
            // Multiplicand shifts left while multiplier shifts right: bit[count] is always bit 0.
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
                wr      = 1'b1;
                wr_res  = acc_d[WIDTH-1:0];
                wr_c    = |acc_d[2*WIDTH-1:WIDTH];
                wr_v    = 1'b0;
                state_d = StIdle;
            end
        end
`else
        if (accept) wr = 1'b1;
`endif
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        if (wr) begin
            out_valid_d = 1'b1;
            result_d    = wr_res;
            carry_d     = wr_c;
            ovf_d       = wr_v;
            zero_d      = (wr_res == '0);
            neg_d       = wr_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
endmodule
